u400_sdram_dqm: RTL and testbench
=================================

// Module: u400_sdram_dqm
// PURPOSE
//  SDRAM byte-lane mask (DQM) sequencer for the U400 local bus card. Sits beside the SDRAM controller
//  on the 68040 local bus, between CPU and SDRAM pins. Decodes SIZ/A[1:0] at transfer start.
//  Tracks TA beats (1 normal, 4 line burst) and drives DQM[3:0] on the negedge command timing.
//  Flags cycles that never terminate.
// PARAMETERS
//  DQM_HOLD    2   clocks DQM stays valid after the final TA (covers CAS latency 2)
//  TA_TIMEOUT  64  clocks in ACTIVE with no TA before abort; 8-bit counter, range 2..255
// PORTS
//  CLK40      in   1  40MHz local bus clock
//  RESETn     in   1  reset, synchronous, active-low
//  TSn        in   1  68040 transfer start, sampled on posedge
//  RAM_SPACE  in   1  address decode hit for SDRAM, qualifies TSn
//  RnW        in   1  1=read, 0=write, captured with TSn
//  A          in   2  A[1:0], captured with TSn
//  SIZ        in   2  00 long, 01 byte, 10 word, 11 line, captured with TSn
//  TAn        in   1  transfer acknowledge (tri-state net), sampled on posedge; Z/1 = no TA
//  DQM        out  4  SDRAM DQ mask, 1=masked; [3]=D31:24 ... [0]=D7:0; registered on negedge
//  BEAT       out  2  TA beats completed in the current cycle
//  BUSY       out  1  1 from the TS capture until IDLE is re-entered
//  TIMEOUT    out  1  one-clock pulse on a timeout abort
// BEHAVIOUR
//  Reset (sync, posedge): state IDLE, DQM=4'b1111, BEAT=0, BUSY=0, TIMEOUT=0, counters 0.
//  States IDLE -> ACTIVE -> HOLD -> IDLE. All sequencing is on posedge. DQM pins copy internal mask on negedge.
//  IDLE: TSn=0 && RAM_SPACE=1 at posedge n -> capture RnW/A/SIZ, load mask, enter ACTIVE, BUSY=1.
//   The DQM pin is valid at negedge n, one clock before the controller's ACTIVATE reaches the pins.
//   TSn=0 && RAM_SPACE=0 -> ignored.
//  Mask (big-endian): long/line 0000; word A1=0 0011, A1=1 1100;
//   byte A=00 0111, 01 1011, 10 1101, 11 1110.
//  ACTIVE: each posedge with TAn=0 -> BEAT+1. Final beat = 1st (non-line) or 4th (line, SIZ=11).
//   Final beat -> HOLD, hold count loaded with DQM_HOLD. TSn seen in ACTIVE -> ignored (protocol violation).
//   TA_TIMEOUT consecutive clocks with no TA -> IDLE, DQM=1111, TIMEOUT=1 for one clock, BEAT=0.
//   The timeout counter clears on every TA.
//  HOLD: mask held; count down to 0 -> IDLE, DQM=1111, BUSY=0, BEAT=0.
//   Qualified TS during HOLD -> the new cycle wins: capture, load the new mask, ACTIVE, BEAT=0.
//   No IDLE clock in between.
//  BEAT wraps 3->0 only through the state return; it never counts past 3.
//  TAn=0 in IDLE or HOLD -> ignored.
//  RESETn low mid-cycle: next posedge forces the reset values; the next negedge drives DQM=1111.
// CONFIGURATION
//  `U400_DQM_READ_MASK_EN defined: reads use the decoded byte mask, the same as writes.
//  Not defined: reads drive DQM=0000 in ACTIVE/HOLD (all lanes driven, CPU ignores unused lanes).
//  Writes are always masked.
// STRUCTURE
//  u400_pkg holds: SIZ encodings (SIZ_LONG/BYTE/WORD/LINE), DQM_NONE=4'b1111, DQM_ALL=4'b0000,
//   the state enum (IDLE/ACTIVE/HOLD) and the LINE_BEATS=4 constant.
//  Sub-module u400_byte_lane_decode: combinational SIZ/A[1:0] -> 4-bit mask, instantiated once.
// TESTING
//  Byte write SIZ=01 A=10, TA after 3 clocks -> DQM 1101 from negedge of TS clock; 1111 2 clks after TA.
//  Line read SIZ=11, TA on 4 consecutive clocks -> DQM 0000 throughout, BEAT 1..3 then 0.
//   BUSY drops DQM_HOLD clocks after the 4th TA.
//  Word read A1=1, macro defined -> DQM=1100; macro undefined -> DQM=0000.
//  Long write, no TA for 64 clocks -> TIMEOUT pulse on clock 64, DQM=1111, BUSY=0.
//  Back-to-back: byte write A=00 TA, then TS (word A1=0) the next clock -> DQM 0111 then 0011 directly.
//  RESETn low during line burst beat 2 -> DQM=1111, BEAT=0, BUSY=0.
//   A TSn with RAM_SPACE=0 afterwards -> stays IDLE.

Source files
------------

// File: rtl/u400_pkg.sv
// Shared encodings for the U400 SDRAM DQM sequencer: SIZ codes, mask constants and FSM states.
package u400_pkg;

    localparam logic [1:0] SIZ_LONG = 2'b00;
    localparam logic [1:0] SIZ_BYTE = 2'b01;
    localparam logic [1:0] SIZ_WORD = 2'b10;
    localparam logic [1:0] SIZ_LINE = 2'b11;

    // DQM is active-high masking: all ones blocks every lane.
    localparam logic [3:0] DQM_NONE = 4'b1111;
    localparam logic [3:0] DQM_ALL  = 4'b0000;

    localparam int unsigned LINE_BEATS = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        HOLD   = 2'd2
    } state_e;

endpackage

// File: rtl/u400_sdram_dqm_if.sv
// 68040 local bus / SDRAM mask signal bundle for the U400 DQM sequencer.
interface u400_sdram_dqm_if;

    logic       TSn;
    logic       RAM_SPACE;
    logic       RnW;
    logic [1:0] A;
    logic [1:0] SIZ;
    logic       TAn;
    logic [3:0] DQM;
    logic [1:0] BEAT;
    logic       BUSY;
    logic       TIMEOUT;

    // Bus side: drives the 68040 transfer signals, observes the sequencer.
    modport master (
        output TSn, RAM_SPACE, RnW, A, SIZ, TAn,
        input  DQM, BEAT, BUSY, TIMEOUT
    );

    // Sequencer side.
    modport slave (
        input  TSn, RAM_SPACE, RnW, A, SIZ, TAn,
        output DQM, BEAT, BUSY, TIMEOUT
    );

endinterface

// File: rtl/u400_byte_lane_decode.sv
// Combinational 68040 SIZ/A[1:0] to big-endian SDRAM byte-lane mask (1 = lane masked).
module u400_byte_lane_decode
    import u400_pkg::*;
(
    input  logic [1:0] siz_i,
    input  logic [1:0] a_i,
    output logic [3:0] mask_o
);

    always_comb begin
        mask_o = DQM_ALL;
        unique case (siz_i)
            SIZ_BYTE: begin
                // Address 0 is the most significant lane (D31:24).
                unique case (a_i)
                    2'b00:   mask_o = 4'b0111;
                    2'b01:   mask_o = 4'b1011;
                    2'b10:   mask_o = 4'b1101;
                    default: mask_o = 4'b1110;
                endcase
            end
            SIZ_WORD: mask_o = a_i[1] ? 4'b1100 : 4'b0011;
            default:  mask_o = DQM_ALL;
        endcase
    end

endmodule

// File: rtl/u400_sdram_dqm.sv
// U400 SDRAM DQM sequencer: decodes the transfer at TS, counts TA beats, drives DQM on negedge.
// Build option: U400_DQM_READ_MASK_EN applies the byte-lane mask to reads as well as writes.
module u400_sdram_dqm
    import u400_pkg::*;
#(
    parameter int unsigned DQM_HOLD   = 2,
    parameter int unsigned TA_TIMEOUT = 64
) (
    input logic             CLK40,
    input logic             RESETn,
    u400_sdram_dqm_if.slave bus
);

    localparam logic [7:0] HoldLoad = 8'(DQM_HOLD);
    localparam logic [7:0] ToLast   = 8'(TA_TIMEOUT - 1);
    localparam logic [1:0] BeatLast = 2'(LINE_BEATS - 1);

    state_e     state_q, state_d;
    logic [3:0] mask_q, mask_d;
    logic [3:0] dqm_q, dqm_d;
    logic [1:0] beat_q, beat_d;
    logic       busy_q, busy_d;
    logic       timeout_q, timeout_d;
    logic       line_q, line_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic [7:0] to_cnt_q, to_cnt_d;

    logic [3:0] lane_mask;
    logic [3:0] start_mask;
    logic       ts_hit;
    logic       ta_hit;
    logic       final_beat;

    u400_byte_lane_decode u_decode (
        .siz_i  (bus.SIZ),
        .a_i    (bus.A),
        .mask_o (lane_mask)
    );

`ifdef U400_DQM_READ_MASK_EN
    logic unused_rnw;
    assign unused_rnw = bus.RnW;
    assign start_mask = lane_mask;
`else
    // Reads enable every lane; the CPU simply ignores the lanes it did not ask for.
    assign start_mask = bus.RnW ? DQM_ALL : lane_mask;
`endif

    assign ts_hit     = ~bus.TSn & bus.RAM_SPACE;
    assign ta_hit     = ~bus.TAn;
    assign final_beat = ~line_q | (beat_q == BeatLast);

    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        beat_d     = beat_q;
        busy_d     = busy_q;
        timeout_d  = 1'b0;
        line_d     = line_q;
        hold_cnt_d = hold_cnt_q;
        to_cnt_d   = to_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (ts_hit) begin
                    state_d    = ACTIVE;
                    mask_d     = start_mask;
                    beat_d     = 2'd0;
                    busy_d     = 1'b1;
                    line_d     = (bus.SIZ == SIZ_LINE);
                    hold_cnt_d = 8'd0;
                    to_cnt_d   = 8'd0;
                end
            end

            ACTIVE: begin
                if (ta_hit) begin
                    to_cnt_d = 8'd0;
                    // The 4th line beat saturates at 3; the return to IDLE clears it.
                    if (beat_q != 2'd3) begin
                        beat_d = beat_q + 2'd1;
                    end
                    if (final_beat) begin
                        state_d    = HOLD;
                        hold_cnt_d = HoldLoad;
                    end
                end else if (to_cnt_q == ToLast) begin
                    state_d    = IDLE;
                    mask_d     = DQM_NONE;
                    beat_d     = 2'd0;
                    busy_d     = 1'b0;
                    timeout_d  = 1'b1;
                    hold_cnt_d = 8'd0;
                    to_cnt_d   = 8'd0;
                end else begin
                    to_cnt_d = to_cnt_q + 8'd1;
                end
            end

            HOLD: begin
                if (ts_hit) begin
                    // A new transfer overlaps the CAS-latency tail; it takes over at once.
                    state_d    = ACTIVE;
                    mask_d     = start_mask;
                    beat_d     = 2'd0;
                    busy_d     = 1'b1;
                    line_d     = (bus.SIZ == SIZ_LINE);
                    hold_cnt_d = 8'd0;
                    to_cnt_d   = 8'd0;
                end else if (hold_cnt_q <= 8'd1) begin
                    state_d    = IDLE;
                    mask_d     = DQM_NONE;
                    beat_d     = 2'd0;
                    busy_d     = 1'b0;
                    hold_cnt_d = 8'd0;
                end else begin
                    hold_cnt_d = hold_cnt_q - 8'd1;
                end
            end

            default: begin
                state_d    = IDLE;
                mask_d     = DQM_NONE;
                beat_d     = 2'd0;
                busy_d     = 1'b0;
                hold_cnt_d = 8'd0;
                to_cnt_d   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge CLK40) begin
        if (!RESETn) begin
            state_q    <= IDLE;
            mask_q     <= DQM_NONE;
            beat_q     <= 2'd0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
            line_q     <= 1'b0;
            hold_cnt_q <= 8'd0;
            to_cnt_q   <= 8'd0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            beat_q     <= beat_d;
            busy_q     <= busy_d;
            timeout_q  <= timeout_d;
            line_q     <= line_d;
            hold_cnt_q <= hold_cnt_d;
            to_cnt_q   <= to_cnt_d;
        end
    end

    // Pins follow the internal mask half a clock later, matching the controller's command timing.
    assign dqm_d = mask_q;

    always_ff @(negedge CLK40) begin
        dqm_q <= dqm_d;
    end

    assign bus.DQM     = dqm_q;
    assign bus.BEAT    = beat_q;
    assign bus.BUSY    = busy_q;
    assign bus.TIMEOUT = timeout_q;

endmodule

// File: tb/tb_u400_sdram_dqm.sv
// Self-checking bench for u400_sdram_dqm: directed scenarios plus random traffic vs. a transfer model.
`timescale 1ns/1ps
module tb_u400_sdram_dqm;

    localparam int unsigned DqmHold   = 2;
    localparam int unsigned TaTimeout = 64;
    localparam int          LineBeats = 4;
`ifdef U400_DQM_READ_MASK_EN
    localparam bit ReadMask = 1'b1;
`else
    localparam bit ReadMask = 1'b0;
`endif

    logic clk;
    logic rstn;
    int   vectors;
    int   miscompares;

    u400_sdram_dqm_if bus_if ();

    u400_sdram_dqm #(
        .DQM_HOLD   (DqmHold),
        .TA_TIMEOUT (TaTimeout)
    ) dut (
        .CLK40  (clk),
        .RESETn (rstn),
        .bus    (bus_if)
    );

    initial clk = 1'b0;
    always #12.5 clk = ~clk;

    // Transfer-level model: phase 0 = no transfer, 1 = awaiting TA, 2 = post-TA hold.
    int         m_phase;
    int         m_beats;
    int         m_idle;
    int         m_hold;
    bit         m_line;
    bit         m_to;
    logic [3:0] m_mask;

    // Bytes covered by the transfer, big-endian: byte address i maps to DQM bit 3-i.
    function automatic logic [3:0] lane_mask(input logic [1:0] siz, input logic [1:0] a);
        int n;
        int off;
        logic [3:0] m;
        n   = (siz == 2'b01) ? 1 : (siz == 2'b10) ? 2 : 4;
        off = (int'(a) / n) * n;
        m   = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            if (i >= off && i < off + n) m[3 - i] = 1'b0;
        end
        return m;
    endfunction

    task automatic model_start();
        m_phase = 1;
        m_beats = 0;
        m_idle  = 0;
        m_line  = (bus_if.SIZ == 2'b11);
        m_mask  = (bus_if.RnW && !ReadMask) ? 4'b0000 : lane_mask(bus_if.SIZ, bus_if.A);
    endtask

    task automatic model_edge();
        m_to = 1'b0;
        if (!rstn) begin
            m_phase = 0;
            m_beats = 0;
        end else if (m_phase != 1) begin
            if (!bus_if.TSn && bus_if.RAM_SPACE) begin
                model_start();
            end else if (m_phase == 2) begin
                m_hold--;
                if (m_hold == 0) m_phase = 0;
            end
        end else if (!bus_if.TAn) begin
            m_beats++;
            m_idle = 0;
            if (m_beats == (m_line ? LineBeats : 1)) begin
                m_phase = 2;
                m_hold  = DqmHold;
            end
        end else begin
            m_idle++;
            if (m_idle == TaTimeout) begin
                m_phase = 0;
                m_to    = 1'b1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One clock: model steps at posedge, outputs checked just after the following negedge.
    task automatic cycle();
        logic [3:0] e_dqm;
        logic [1:0] e_beat;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        #1;
        e_dqm  = (m_phase == 0) ? 4'b1111 : m_mask;
        e_beat = (m_phase == 0) ? 2'd0 : 2'((m_beats > 3) ? 3 : m_beats);
        chk("dqm", bus_if.DQM, e_dqm);
        chk("beat", 4'(bus_if.BEAT), 4'(e_beat));
        chk("busy", 4'(bus_if.BUSY), 4'(m_phase != 0));
        chk("timeout", 4'(bus_if.TIMEOUT), 4'(m_to));
    endtask

    task automatic drive(input logic ts_n, input logic ram, input logic rnw,
                         input logic [1:0] a, input logic [1:0] siz, input logic ta_n);
        bus_if.TSn       = ts_n;
        bus_if.RAM_SPACE = ram;
        bus_if.RnW       = rnw;
        bus_if.A         = a;
        bus_if.SIZ       = siz;
        bus_if.TAn       = ta_n;
    endtask

    task automatic quiet(input int n);
        drive(1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 1'b1);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        m_phase     = 0;
        m_beats     = 0;
        m_idle      = 0;
        m_hold      = 0;
        m_line      = 1'b0;
        m_to        = 1'b0;
        m_mask      = 4'b1111;
        rstn        = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 1'b1);
        cycle();
        cycle();
        chk("reset_dqm", bus_if.DQM, 4'b1111);
        rstn = 1'b1;
        quiet(2);

        // Byte write A=10, TA three clocks after TS.
        drive(1'b0, 1'b1, 1'b0, 2'b10, 2'b01, 1'b1);
        cycle();
        chk("byte_wr_dqm", bus_if.DQM, 4'b1101);
        quiet(2);
        drive(1'b1, 1'b0, 1'b0, 2'b10, 2'b01, 1'b0);
        cycle();
        quiet(4);

        // Line read, four consecutive TAs.
        drive(1'b0, 1'b1, 1'b1, 2'b00, 2'b11, 1'b1);
        cycle();
        drive(1'b1, 1'b0, 1'b1, 2'b00, 2'b11, 1'b0);
        for (int i = 0; i < 4; i++) cycle();
        chk("line_rd_dqm", bus_if.DQM, 4'b0000);
        quiet(1);
        chk("line_rd_busy_hold", 4'(bus_if.BUSY), 4'd1);
        quiet(3);

        // Word read A1=1; stray TS while active is ignored.
        drive(1'b0, 1'b1, 1'b1, 2'b11, 2'b10, 1'b1);
        cycle();
        chk("word_rd_dqm", bus_if.DQM, ReadMask ? 4'b1100 : 4'b0000);
        drive(1'b0, 1'b1, 1'b0, 2'b00, 2'b01, 1'b1);
        cycle();
        drive(1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0);
        cycle();
        quiet(3);

        // Long write that never terminates.
        drive(1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b1);
        cycle();
        quiet(TaTimeout - 1);
        quiet(1);
        chk("timeout_pulse", 4'(bus_if.TIMEOUT), 4'd1);
        chk("timeout_dqm", bus_if.DQM, 4'b1111);
        quiet(2);

        // Back-to-back: byte write A=00, then word A1=0 TS during the hold.
        drive(1'b0, 1'b1, 1'b0, 2'b00, 2'b01, 1'b1);
        cycle();
        drive(1'b1, 1'b0, 1'b0, 2'b00, 2'b01, 1'b0);
        cycle();
        drive(1'b0, 1'b1, 1'b0, 2'b00, 2'b10, 1'b1);
        cycle();
        chk("b2b_word_dqm", bus_if.DQM, 4'b0011);
        drive(1'b1, 1'b0, 1'b0, 2'b00, 2'b10, 1'b0);
        cycle();
        quiet(4);

        // Reset during line burst beat 2, then an unqualified TS.
        drive(1'b0, 1'b1, 1'b0, 2'b00, 2'b11, 1'b1);
        cycle();
        drive(1'b1, 1'b0, 1'b0, 2'b00, 2'b11, 1'b0);
        cycle();
        cycle();
        rstn = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 2'b00, 2'b11, 1'b1);
        cycle();
        chk("rst_mid_dqm", bus_if.DQM, 4'b1111);
        rstn = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1);
        cycle();
        chk("unqual_ts_busy", 4'(bus_if.BUSY), 4'd0);
        quiet(2);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            rstn = ($urandom_range(0, 149) != 0);
            drive(1'($urandom_range(0, 5) != 0), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 2) != 0));
            cycle();
        end
        rstn = 1'b1;
        quiet(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
